// File: rtl/NVM_pkg.sv
// ---------------------------------------------------------------------------
// NVM_pkg
// Shared types and default sizing for the NVM garbage-collection sequencer.
//   block_t     : physical block index (BLK_W bits)
//   gc_state_t  : GC sequencer state encoding
//   NUM_BLK_DEF : default number of physical blocks
//   GC_THRESH_DEF : default free-block low watermark
//   ERASE_TMO_DEF : default erase watchdog length (only with
//                   GC_ERASE_TIMEOUT_EN defined)
// ---------------------------------------------------------------------------
package NVM_pkg;

    localparam int NUM_BLK_DEF   = 64;
    localparam int GC_THRESH_DEF = 4;
`ifdef GC_ERASE_TIMEOUT_EN
    localparam int ERASE_TMO_DEF = 1024;
`endif

    localparam int BLK_W = $clog2(NUM_BLK_DEF);

    typedef logic [BLK_W-1:0] block_t;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_INIT    = 4'd1,
        S_REQ     = 4'd2,
        S_VICTIM  = 4'd3,
        S_MOVE    = 4'd4,
        S_PAUSE   = 4'd5,
        S_ERASE   = 4'd6,
        S_ERWAIT  = 4'd7,
        S_RECOVER = 4'd8,
        S_DONE    = 4'd9
    } gc_state_t;

endpackage

// File: rtl/free_blk_counter.sv
// ---------------------------------------------------------------------------
// free_blk_counter
// Up/down saturating count of free blocks with a low-watermark flag.
//   clk, rst    : clock, asynchronous active-high reset
//   clr_i       : synchronous clear (wins over inc/dec)
//   inc_i       : one block returned to the free FIFO
//   dec_i       : one block consumed by the writer
//   free_cnt_o  : current free-block count (0..NUM_BLK)
//   low_o       : free_cnt_o < GC_THRESH
// ---------------------------------------------------------------------------
module free_blk_counter #(
    parameter int NUM_BLK   = 64,
    parameter int GC_THRESH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr_i,
    input  logic                         inc_i,
    input  logic                         dec_i,
    output logic [$clog2(NUM_BLK+1)-1:0] free_cnt_o,
    output logic                         low_o
);

    localparam int CNT_W = $clog2(NUM_BLK+1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Simultaneous inc and dec cancel out; decrement at zero and increment
    // at full are dropped rather than wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !dec_i) begin
            if (cnt_q != CNT_W'(NUM_BLK)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (dec_i && !inc_i) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign free_cnt_o = cnt_q;
    assign low_o      = (cnt_q < CNT_W'(GC_THRESH));

endmodule

// File: rtl/gc_sequencer.sv
// ---------------------------------------------------------------------------
// gc_sequencer
// Control FSM for NVM garbage collection: fills the free-block FIFO on
// init, tracks the free count, requests GC below the watermark, and once
// granted moves/erases/recovers one victim block.
// Optional feature macro: GC_ERASE_TIMEOUT_EN (erase watchdog, gc_error).
//
// Ports:
//   CLK, RST          : clock, asynchronous active-high reset
//   gc_ini            : init pulse (honoured only in IDLE, beats GC)
//   gc_start          : GC grant
//   active_request    : host write pending, pauses page moves
//   blk_alloc         : writer consumed one free block
//   invalid_flag/_blk : victim candidate from the remap table
//   move_done_flag    : victim has no valid pages left
//   erase_done        : flash erase complete
//   gc_request        : GC wanted (REQ state)
//   gc_interrupt      : page move paused by host
//   request_done      : 1-cycle end-of-GC pulse
//   erase_blk         : latched victim
//   move_flag         : remap table may move victim pages
//   erase_en          : 1-cycle erase command
//   recover_blk       : block pushed to the free FIFO
//   fifo_recover_en   : free FIFO push strobe
//   free_cnt          : free blocks available
//   init_busy         : INIT in progress
//   gc_error          : erase watchdog expired (GC_ERASE_TIMEOUT_EN only)
//
// All outputs are registered: each transition loads the outputs of the
// state being entered, so they line up with state_q.
// ---------------------------------------------------------------------------
module gc_sequencer
    import NVM_pkg::*;
#(
`ifdef GC_ERASE_TIMEOUT_EN
    parameter int ERASE_TMO = ERASE_TMO_DEF,
`endif
    parameter int NUM_BLK   = NUM_BLK_DEF,
    parameter int GC_THRESH = GC_THRESH_DEF
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         gc_ini,
    input  logic                         gc_start,
    input  logic                         active_request,
    input  logic                         blk_alloc,
    input  logic                         invalid_flag,
    input  logic [$clog2(NUM_BLK)-1:0]   invalid_blk,
    input  logic                         move_done_flag,
    input  logic                         erase_done,
    output logic                         gc_request,
    output logic                         gc_interrupt,
    output logic                         request_done,
    output logic [$clog2(NUM_BLK)-1:0]   erase_blk,
    output logic                         move_flag,
    output logic                         erase_en,
    output logic [$clog2(NUM_BLK)-1:0]   recover_blk,
    output logic                         fifo_recover_en,
`ifdef GC_ERASE_TIMEOUT_EN
    output logic                         gc_error,
`endif
    output logic [$clog2(NUM_BLK+1)-1:0] free_cnt,
    output logic                         init_busy
);

    localparam int B_W   = $clog2(NUM_BLK);
    localparam int CNT_W = $clog2(NUM_BLK+1);
`ifdef GC_ERASE_TIMEOUT_EN
    localparam int TMO_W = $clog2(ERASE_TMO+1);
`endif

    gc_state_t        state_q;
    logic [CNT_W-1:0] index_q;
    logic             gc_request_q;
    logic             gc_interrupt_q;
    logic             request_done_q;
    logic [B_W-1:0]   erase_blk_q;
    logic             move_flag_q;
    logic             erase_en_q;
    logic [B_W-1:0]   recover_blk_q;
    logic             fifo_recover_en_q;
    logic             init_busy_q;
`ifdef GC_ERASE_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt_q;
    logic             gc_error_q;
`endif

    logic             init_start;
    logic             free_low;

    // The counter is cleared on the same edge that enters INIT, so the
    // first push of the init sweep counts from zero.
    assign init_start = (state_q == S_IDLE) && gc_ini;

    free_blk_counter #(
        .NUM_BLK   (NUM_BLK),
        .GC_THRESH (GC_THRESH)
    ) u_free_cnt (
        .clk        (CLK),
        .rst        (RST),
        .clr_i      (init_start),
        .inc_i      (fifo_recover_en_q),
        .dec_i      (blk_alloc),
        .free_cnt_o (free_cnt),
        .low_o      (free_low)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q           <= S_IDLE;
            index_q           <= '0;
            gc_request_q      <= 1'b0;
            gc_interrupt_q    <= 1'b0;
            request_done_q    <= 1'b0;
            erase_blk_q       <= '0;
            move_flag_q       <= 1'b0;
            erase_en_q        <= 1'b0;
            recover_blk_q     <= '0;
            fifo_recover_en_q <= 1'b0;
            init_busy_q       <= 1'b0;
`ifdef GC_ERASE_TIMEOUT_EN
            tmo_cnt_q         <= '0;
            gc_error_q        <= 1'b0;
`endif
        end else begin
            // Single-cycle strobes drop unless the case below re-asserts them.
            erase_en_q        <= 1'b0;
            request_done_q    <= 1'b0;
            fifo_recover_en_q <= 1'b0;
`ifdef GC_ERASE_TIMEOUT_EN
            gc_error_q        <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (gc_ini) begin
                        state_q           <= S_INIT;
                        init_busy_q       <= 1'b1;
                        fifo_recover_en_q <= 1'b1;
                        recover_blk_q     <= '0;
                        index_q           <= CNT_W'(1);
                    end else if (free_low) begin
                        state_q      <= S_REQ;
                        gc_request_q <= 1'b1;
                    end
                end
                S_INIT: begin
                    if (index_q < CNT_W'(NUM_BLK)) begin
                        fifo_recover_en_q <= 1'b1;
                        recover_blk_q     <= index_q[B_W-1:0];
                        index_q           <= index_q + CNT_W'(1);
                    end else begin
                        state_q     <= S_IDLE;
                        init_busy_q <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (gc_start) begin
                        state_q      <= S_VICTIM;
                        gc_request_q <= 1'b0;
                    end
                end
                S_VICTIM: begin
                    if (invalid_flag) begin
                        state_q     <= S_MOVE;
                        erase_blk_q <= invalid_blk;
                        move_flag_q <= 1'b1;
                    end
                end
                S_MOVE: begin
                    // Completion beats a host preemption in the same cycle.
                    if (move_done_flag) begin
                        state_q     <= S_ERASE;
                        move_flag_q <= 1'b0;
                        erase_en_q  <= 1'b1;
                    end else if (active_request) begin
                        state_q        <= S_PAUSE;
                        move_flag_q    <= 1'b0;
                        gc_interrupt_q <= 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (move_done_flag) begin
                        state_q        <= S_ERASE;
                        gc_interrupt_q <= 1'b0;
                        erase_en_q     <= 1'b1;
                    end else if (!active_request) begin
                        state_q        <= S_MOVE;
                        gc_interrupt_q <= 1'b0;
                        move_flag_q    <= 1'b1;
                    end
                end
                S_ERASE: begin
                    state_q   <= S_ERWAIT;
`ifdef GC_ERASE_TIMEOUT_EN
                    tmo_cnt_q <= '0;
`endif
                end
                S_ERWAIT: begin
                    if (erase_done) begin
                        state_q           <= S_RECOVER;
                        fifo_recover_en_q <= 1'b1;
                        recover_blk_q     <= erase_blk_q;
`ifdef GC_ERASE_TIMEOUT_EN
                    end else if (tmo_cnt_q == TMO_W'(ERASE_TMO - 1)) begin
                        // Block is retired as bad: never returned to the FIFO.
                        state_q        <= S_IDLE;
                        gc_error_q     <= 1'b1;
                        request_done_q <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
`endif
                    end
                end
                S_RECOVER: begin
                    state_q        <= S_DONE;
                    request_done_q <= 1'b1;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign gc_request      = gc_request_q;
    assign gc_interrupt    = gc_interrupt_q;
    assign request_done    = request_done_q;
    assign erase_blk       = erase_blk_q;
    assign move_flag       = move_flag_q;
    assign erase_en        = erase_en_q;
    assign recover_blk     = recover_blk_q;
    assign fifo_recover_en = fifo_recover_en_q;
    assign init_busy       = init_busy_q;
`ifdef GC_ERASE_TIMEOUT_EN
    assign gc_error        = gc_error_q;
`endif

endmodule

// File: tb/tb_gc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_gc_sequencer
// Directed bench for gc_sequencer (NUM_BLK=64, GC_THRESH=4). Strobe events
// (free-FIFO pushes, erase commands, GC completion) are queued as expected
// transactions by the stimulus and checked by an independent monitor;
// level outputs are checked inline.
// ---------------------------------------------------------------------------
module tb_gc_sequencer;

    logic       CLK = 1'b0;
    logic       RST;
    logic       gc_ini;
    logic       gc_start;
    logic       active_request;
    logic       blk_alloc;
    logic       invalid_flag;
    logic [5:0] invalid_blk;
    logic       move_done_flag;
    logic       erase_done;
    logic       gc_request;
    logic       gc_interrupt;
    logic       request_done;
    logic [5:0] erase_blk;
    logic       move_flag;
    logic       erase_en;
    logic [5:0] recover_blk;
    logic       fifo_recover_en;
`ifdef GC_ERASE_TIMEOUT_EN
    logic       gc_error;
`endif
    logic [6:0] free_cnt;
    logic       init_busy;

    always #5 CLK = ~CLK;

    gc_sequencer dut (
        .CLK             (CLK),
        .RST             (RST),
        .gc_ini          (gc_ini),
        .gc_start        (gc_start),
        .active_request  (active_request),
        .blk_alloc       (blk_alloc),
        .invalid_flag    (invalid_flag),
        .invalid_blk     (invalid_blk),
        .move_done_flag  (move_done_flag),
        .erase_done      (erase_done),
        .gc_request      (gc_request),
        .gc_interrupt    (gc_interrupt),
        .request_done    (request_done),
        .erase_blk       (erase_blk),
        .move_flag       (move_flag),
        .erase_en        (erase_en),
        .recover_blk     (recover_blk),
        .fifo_recover_en (fifo_recover_en),
`ifdef GC_ERASE_TIMEOUT_EN
        .gc_error        (gc_error),
`endif
        .free_cnt        (free_cnt),
        .init_busy       (init_busy)
    );

    typedef enum int { EV_REC, EV_ERASE, EV_DONE } ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        int       data;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    function automatic string kname(input ev_kind_e k);
        case (k)
            EV_REC:   return "recover";
            EV_ERASE: return "erase";
            default:  return "done";
        endcase
    endfunction

    task automatic expect_ev(input ev_kind_e k, input int d);
        ev_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
            $display("check %s: %0d ok", name, act);
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic sb_pop(input ev_kind_e k, input int d);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL sb_unexpected: got %s data %0d, queue empty", kname(k), d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == k && e.data == d) begin
                n_pass++;
                $display("sb %s data %0d ok", kname(k), d);
            end else begin
                $display("FAIL sb_%s: got %s data %0d expected %s data %0d",
                         kname(e.kind), kname(k), d, kname(e.kind), e.data);
            end
        end
    endtask

    // Monitor: every strobe the DUT presents consumes one expected event.
    always @(negedge CLK) begin
        if (!RST) begin
            if (fifo_recover_en) sb_pop(EV_REC, int'(recover_blk));
            if (erase_en)        sb_pop(EV_ERASE, int'(erase_blk));
            if (request_done)    sb_pop(EV_DONE, int'(free_cnt));
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int busy_cycles;
        int int_cycles;
        int mf_low_cycles;
        int any_out;

        RST            = 1'b1;
        gc_ini         = 1'b1;
        gc_start       = 1'b0;
        active_request = 1'b0;
        blk_alloc      = 1'b0;
        invalid_flag   = 1'b0;
        invalid_blk    = '0;
        move_done_flag = 1'b0;
        erase_done     = 1'b0;

        // ---- reset state ----
        repeat (3) @(negedge CLK);
        check("rst_free_cnt", int'(free_cnt), 0);
        check("rst_gc_request", int'(gc_request), 0);
        check("rst_fifo_en", int'(fifo_recover_en), 0);
        check("rst_init_busy", int'(init_busy), 0);

        // ---- init sweep: blocks 0..63 pushed on consecutive cycles ----
        for (int i = 0; i < 64; i++) expect_ev(EV_REC, i);
        RST = 1'b0;
        step();
        gc_ini = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (init_busy) busy_cycles++;
            else break;
        end
        check("init_busy_cycles", busy_cycles, 64);
        check("init_free_cnt", int'(free_cnt), 64);
        check("init_fifo_en_low", int'(fifo_recover_en), 0);

        // ---- drain to 3 free blocks -> GC requested ----
        blk_alloc = 1'b1;
        repeat (61) @(posedge CLK);
        #1 blk_alloc = 1'b0;
        @(negedge CLK);
        check("alloc_free_cnt", int'(free_cnt), 3);
        @(negedge CLK);
        check("gc_request_high", int'(gc_request), 1);

        // ---- grant with victim already offered ----
        gc_start     = 1'b1;
        invalid_flag = 1'b1;
        invalid_blk  = 6'd17;
        step();
        gc_start = 1'b0;
        @(negedge CLK);
        check("grant_req_dropped", int'(gc_request), 0);
        check("grant_move_flag_1cyc", int'(move_flag), 0);
        @(negedge CLK);
        check("grant_move_flag_2cyc", int'(move_flag), 1);
        check("victim_latched", int'(erase_blk), 17);
        invalid_flag = 1'b0;

        // ---- host preemption for 5 cycles ----
        step();
        active_request = 1'b1;
        int_cycles     = 0;
        mf_low_cycles  = 0;
        for (int j = 0; j < 8; j++) begin
            @(negedge CLK);
            if (gc_interrupt) int_cycles++;
            if (!move_flag) mf_low_cycles++;
            step();
            if (j == 4) active_request = 1'b0;
        end
        check("pause_interrupt_cycles", int_cycles, 5);
        check("pause_move_flag_low", mf_low_cycles, 5);
        @(negedge CLK);
        check("resume_move_flag", int'(move_flag), 1);

        // ---- finish move, erase, recover 17, free_cnt 3 -> 4 ----
        expect_ev(EV_ERASE, 17);
        expect_ev(EV_REC, 17);
        expect_ev(EV_DONE, 4);
        step();
        move_done_flag = 1'b1;
        step();
        move_done_flag = 1'b0;
        repeat (3) step();
        erase_done = 1'b1;
        step();
        erase_done = 1'b0;
        @(negedge CLK);
        check("recover_after_erase_done", int'(fifo_recover_en), 1);
        @(negedge CLK);
        check("done_after_erase_done", int'(request_done), 1);
        @(negedge CLK);
        @(negedge CLK);
        check("gc1_free_cnt", int'(free_cnt), 4);
        check("gc1_no_new_request", int'(gc_request), 0);

        // ---- second GC: done+host same cycle, alloc during recover ----
        blk_alloc = 1'b1;
        step();
        blk_alloc = 1'b0;
        step();
        gc_start     = 1'b1;
        invalid_flag = 1'b1;
        invalid_blk  = 6'd42;
        step();
        gc_start = 1'b0;
        step();
        invalid_flag = 1'b0;
        expect_ev(EV_ERASE, 42);
        expect_ev(EV_REC, 42);
        expect_ev(EV_DONE, 3);
        move_done_flag = 1'b1;
        active_request = 1'b1;
        step();
        move_done_flag = 1'b0;
        active_request = 1'b0;
        @(negedge CLK);
        check("done_beats_host_no_int", int'(gc_interrupt), 0);
        check("done_beats_host_erase", int'(erase_en), 1);
        step();
        erase_done = 1'b1;
        step();
        erase_done = 1'b0;
        blk_alloc  = 1'b1;
        step();
        blk_alloc = 1'b0;
        @(negedge CLK);
        check("inc_dec_same_cycle", int'(free_cnt), 3);

        // ---- alloc below zero is ignored ----
        blk_alloc = 1'b1;
        repeat (5) @(posedge CLK);
        #1 blk_alloc = 1'b0;
        @(negedge CLK);
        check("alloc_at_zero", int'(free_cnt), 0);
        check("req_at_zero", int'(gc_request), 1);

        // ---- reset while waiting for erase ----
        gc_start     = 1'b1;
        invalid_flag = 1'b1;
        invalid_blk  = 6'd5;
        step();
        gc_start = 1'b0;
        step();
        invalid_flag   = 1'b0;
        expect_ev(EV_ERASE, 5);
        move_done_flag = 1'b1;
        step();
        move_done_flag = 1'b0;
        step();
        #1 RST = 1'b1;
        #1;
        check("rst_async_erase_blk", int'(erase_blk), 0);
        any_out = int'(gc_request) + int'(gc_interrupt) + int'(request_done)
                + int'(move_flag) + int'(erase_en) + int'(recover_blk)
                + int'(fifo_recover_en) + int'(free_cnt) + int'(init_busy);
        check("rst_async_outputs", any_out, 0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check("post_rst_request", int'(gc_request), 1);

`ifdef GC_ERASE_TIMEOUT_EN
        // ---- erase watchdog: no erase_done -> error, block not recovered ----
        gc_start     = 1'b1;
        invalid_flag = 1'b1;
        invalid_blk  = 6'd9;
        step();
        gc_start = 1'b0;
        step();
        invalid_flag   = 1'b0;
        expect_ev(EV_ERASE, 9);
        expect_ev(EV_DONE, 0);
        move_done_flag = 1'b1;
        step();
        move_done_flag = 1'b0;
        begin
            int waited;
            waited = 0;
            while (!request_done && waited < 1200) begin
                @(negedge CLK);
                waited++;
            end
            check("tmo_done_seen", int'(request_done), 1);
            check("tmo_gc_error", int'(gc_error), 1);
            check("tmo_no_recover", int'(fifo_recover_en), 0);
        end
`endif

        // ---- every expected strobe must have been observed ----
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge CLK);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: time %0t expected finish before 200000", $time);
        $fatal(1);
    end

endmodule

// File: doc/gc_sequencer.md
Name: gc_sequencer

Overview:
- Control FSM for NVM garbage collection.
- Initializes the free-block FIFO and tracks the free-block count.
- When the count falls below a watermark, requests GC from the overall controller.
- Once granted: latches a victim from the remapping table, moves its valid pages (pausable by host writes), erases it, and recovers it into the free-block FIFO.

Parameters:
- NUM_BLK, 64, number of physical blocks; block_t width BLK_W = $clog2(NUM_BLK)
- GC_THRESH, 4, GC requested while free_cnt < GC_THRESH
- ERASE_TMO, 1024, erase watchdog cycles (used only with the optional feature)

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous, active-high reset
- gc_ini  in  1  init pulse from overall controller
- gc_start  in  1  GC grant from overall controller
- active_request  in  1  host write pending; preempts page moves
- blk_alloc  in  1  writer consumed one free block
- invalid_flag  in  1  remap table: invalid_blk valid
- invalid_blk  in  BLK_W  victim candidate
- move_done_flag  in  1  remap table: victim has no valid pages left
- erase_done  in  1  flash erase complete
- gc_request  out  1  GC wanted
- gc_interrupt  out  1  GC paused by host
- request_done  out  1  GC cycle finished (1-cycle pulse)
- erase_blk  out  BLK_W  latched victim
- move_flag  out  1  remap table may move victim pages
- erase_en  out  1  erase command (1-cycle pulse)
- recover_blk  out  BLK_W  block pushed to free FIFO
- fifo_recover_en  out  1  free FIFO push strobe
- free_cnt  out  $clog2(NUM_BLK+1)  free blocks available
- init_busy  out  1  INIT in progress

Behaviour:
- Reset: all outputs 0; state IDLE; free_cnt 0.
- States: IDLE, INIT, REQ, VICTIM, MOVE, PAUSE, ERASE, ERWAIT, RECOVER, DONE.
- IDLE
  - gc_ini=1 → INIT; gc_ini has priority over GC.
  - Else free_cnt < GC_THRESH → REQ.
  - gc_ini is ignored in all other states.
- INIT
  - On entry, free_cnt cleared and index cleared.
  - Each cycle: fifo_recover_en=1, recover_blk=index, index++.
  - After NUM_BLK pushes (NUM_BLK cycles) → IDLE with free_cnt=NUM_BLK.
  - init_busy=1 throughout.
- REQ: gc_request=1 (registered) until gc_start is sampled high → VICTIM.
- VICTIM
  - Wait for invalid_flag.
  - On the cycle it is sampled, latch erase_blk=invalid_blk → MOVE.
- MOVE
  - move_flag=1.
  - move_done_flag → ERASE, even if active_request is high in the same cycle.
  - Else active_request → PAUSE.
- PAUSE
  - move_flag=0, gc_interrupt=1.
  - move_done_flag is still accepted here → ERASE.
  - active_request low → MOVE.
- ERASE: erase_en=1 for one cycle → ERWAIT.
- ERWAIT: erase_done → RECOVER.
- RECOVER: fifo_recover_en=1, recover_blk=erase_blk for one cycle → DONE.
- DONE: request_done=1 for one cycle → IDLE.
- free_cnt update
  - +1 on fifo_recover_en; −1 on blk_alloc; both in the same cycle → unchanged.
  - blk_alloc at 0 is ignored.
  - Increment saturates at NUM_BLK.
- Latencies
  - gc_start sampled → move_flag high 2 cycles later, given invalid_flag already high.
  - erase_done → request_done 2 cycles later.
- RST asserted mid-operation returns to IDLE immediately and clears all outputs and free_cnt; the controller must reissue gc_ini.

Optional Feature:
- Macro: GC_ERASE_TIMEOUT_EN.
- When defined:
  - ERWAIT runs a cycle counter.
  - If erase_done is not seen within ERASE_TMO cycles: pulse gc_error (extra 1-bit output) and request_done, skip RECOVER (block retired as bad) → IDLE.
  - erase_done on the same cycle the counter expires counts as success.
- When undefined: no counter, no gc_error port; ERWAIT waits indefinitely.

Decomposition:
- NVM_pkg: block_t, gc_state_t enum, NUM_BLK, GC_THRESH defaults.
- Sub-module free_blk_counter: up/down saturating counter with free_cnt and low-watermark compare.
- FSM stays in gc_sequencer.

Test Plan:
- Reset, then gc_ini pulse (NUM_BLK=64) → fifo_recover_en high 64 consecutive cycles with recover_blk 0..63; free_cnt=64; init_busy low afterwards.
- 61 blk_alloc pulses → free_cnt=3, gc_request=1; gc_start=1, invalid_flag=1, invalid_blk=17 → erase_blk=17, move_flag=1 two cycles after grant.
- active_request high for 5 cycles during MOVE → move_flag=0 and gc_interrupt=1 for 5 cycles, then move_flag=1 resumes.
- move_done_flag, then erase_done → erase_en pulse once; then recover_blk=17 with fifo_recover_en; request_done pulse; free_cnt=4.
- blk_alloc and fifo_recover_en in the same cycle → free_cnt unchanged; blk_alloc at free_cnt=0 → stays 0.
- RST asserted in ERWAIT → all outputs 0 immediately. With GC_ERASE_TIMEOUT_EN and erase_done withheld for 1024 cycles → gc_error pulse, no recovery.
